// File: rtl/axi_pkg.sv
// Shared AXI constants, the read-master state type and the transfer-size helper.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DRAIN
    } rd_state_t;

    // AxSIZE encoding is log2 of the bytes per beat.
    function automatic logic [2:0] axi_size_for_width(input int width);
        case (width)
            8:       return 3'd0;
            16:      return 3'd1;
            32:      return 3'd2;
            64:      return 3'd3;
            128:     return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/axi_rd_out_reg.sv
// Single-entry output register for R beats; generates rready so the stream runs at full throughput.
module axi_rd_out_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  rvalid,
    input  logic                  beat_last,
    output logic                  rready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic load;

    // Room exists when the register is empty or is being emptied this cycle.
    assign rready = enable && (!out_valid || out_ready);
    assign load   = rvalid && rready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= rdata;
            out_last  <= beat_last;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_read_master.sv
// AXI4 burst-read master: one INCR burst at a time, beats re-presented on a registered stream.
// Optional AXI_RD_RESP_CHECK_EN adds rresp checking and the err_resp capture port.
module axi_read_master
    import axi_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [7:0]               cmd_len,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    output logic [ADDRESS_WIDTH-1:0] araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [DATA_WIDTH-1:0]    rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     done,
    output logic                     err
`ifdef AXI_RD_RESP_CHECK_EN
    ,
    output logic [1:0]               err_resp
`endif
);

    rd_state_t  state;
    logic [7:0] count;
    logic       data_phase;
    logic       beat_load;
    logic       last_beat;

    assign cmd_ready  = (state == ST_IDLE);
    assign arsize     = axi_size_for_width(DATA_WIDTH);
    assign arburst    = AXI_BURST_INCR;
    assign data_phase = (state == ST_DATA);
    assign beat_load  = rvalid && rready;
    assign last_beat  = (count == 8'd0);
    assign done       = (state == ST_DRAIN) && out_valid && out_ready && out_last;

`ifndef AXI_RD_RESP_CHECK_EN
    logic unused_rresp;
    assign unused_rresp = ^rresp;
`endif

    axi_rd_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_reg (
        .clk      (aclk),
        .rst      (areset),
        .enable   (data_phase),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .beat_last(last_beat),
        .rready   (rready),
        .out_data (out_data),
        .out_last (out_last),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    // Burst length is governed by the internal counter; rlast is only cross-checked against it.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state   <= ST_IDLE;
            araddr  <= '0;
            arlen   <= '0;
            arvalid <= 1'b0;
            count   <= '0;
            err     <= 1'b0;
`ifdef AXI_RD_RESP_CHECK_EN
            err_resp <= AXI_RESP_OKAY;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        araddr  <= cmd_addr;
                        arlen   <= cmd_len;
                        count   <= cmd_len;
                        arvalid <= 1'b1;
                        err     <= 1'b0;
`ifdef AXI_RD_RESP_CHECK_EN
                        err_resp <= AXI_RESP_OKAY;
`endif
                        state   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat_load) begin
                        if (rlast != last_beat) begin
                            err <= 1'b1;
                        end
`ifdef AXI_RD_RESP_CHECK_EN
                        if (rresp != AXI_RESP_OKAY) begin
                            err <= 1'b1;
                            if (err_resp == AXI_RESP_OKAY) begin
                                err_resp <= rresp;
                            end
                        end
`endif
                        if (last_beat) begin
                            state <= ST_DRAIN;
                        end else begin
                            count <= count - 8'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_master.sv
// Directed bench for axi_read_master with a behavioural AXI read responder and stream collector.
module tb_axi_read_master;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          aclk = 1'b0;
    logic          areset;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic          done;
    logic          err;
`ifdef AXI_RD_RESP_CHECK_EN
    logic [1:0]    err_resp;
`endif

    axi_read_master #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .araddr   (araddr),
        .arlen    (arlen),
        .arsize   (arsize),
        .arburst  (arburst),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rlast    (rlast),
        .rvalid   (rvalid),
        .rready   (rready),
        .out_data (out_data),
        .out_last (out_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .done     (done),
        .err      (err)
`ifdef AXI_RD_RESP_CHECK_EN
        ,
        .err_resp (err_resp)
`endif
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Responder memory model: each beat carries its burst base address and beat index.
    function automatic logic [31:0] beatData(input logic [7:0] base, input int k);
        logic [7:0] kk;
        kk = 8'(k);
        return {16'hBEEF, base, kk};
    endfunction

    bit         ar_block  = 1'b0;
    int         rlast_bad = -1;
    int         rresp_bad = -1;
    int         ar_count  = 0;
    bit         rsp_active = 1'b0;
    logic [7:0] rsp_base;
    int         rsp_len;
    int         rsp_beat;

    initial begin
        logic       ar_hs;
        logic       r_hs;
        logic [7:0] cap_addr;
        logic [7:0] cap_len;
        arready = 1'b1;
        rvalid  = 1'b0;
        rdata   = '0;
        rlast   = 1'b0;
        rresp   = 2'b00;
        forever begin
            @(negedge aclk);
            ar_hs    = arvalid && arready;
            r_hs     = rvalid && rready;
            cap_addr = araddr;
            cap_len  = arlen;
            @(posedge aclk);
            #1;
            if (areset) begin
                rsp_active = 1'b0;
            end else begin
                if (r_hs) begin
                    rsp_beat++;
                    if (rsp_beat > rsp_len) rsp_active = 1'b0;
                end
                if (ar_hs) begin
                    ar_count++;
                    rsp_base   = cap_addr;
                    rsp_len    = int'(cap_len);
                    rsp_beat   = 0;
                    rsp_active = 1'b1;
                end
            end
            arready = !ar_block;
            rvalid  = rsp_active;
            rdata   = rsp_active ? beatData(rsp_base, rsp_beat) : '0;
            rlast   = rsp_active && ((rlast_bad >= 0) ? (rsp_beat == rlast_bad) : (rsp_beat == rsp_len));
            rresp   = (rsp_active && rsp_beat == rresp_bad) ? 2'b10 : 2'b00;
        end
    end

    bit   bp_mode = 1'b0;
    int   cyc = 0;
    logic bp_pattern [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            out_ready = bp_mode ? bp_pattern[cyc % 4] : 1'b1;
            cyc++;
        end
    end

    logic [31:0] got_data [$];
    bit          got_last [$];
    int          done_count = 0;
    bit          holding = 1'b0;
    logic [31:0] held;

    // Collector: records handed-off beats and watches stall behaviour on the output stream.
    initial begin
        forever begin
            @(negedge aclk);
            if (!areset) begin
                if (out_valid && out_ready) begin
                    got_data.push_back(out_data);
                    got_last.push_back(out_last);
                end
                if (done) done_count++;
                if (out_valid && !out_ready) checkOutput("rready_while_stalled", rready, 0);
                if (holding && out_valid) checkOutput("data_held_while_stalled", out_data, held);
                holding = out_valid && !out_ready;
                held    = out_data;
            end else begin
                holding = 1'b0;
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] len);
        int budget;
        budget = 0;
        @(negedge aclk);
        while (!cmd_ready && budget < 1000) begin
            @(negedge aclk);
            budget++;
        end
        if (!cmd_ready) checkOutput("cmd_ready_timeout", cmd_ready, 1);
        got_data.delete();
        got_last.delete();
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_valid = 1'b1;
        @(posedge aclk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic waitDone(input int start);
        int budget;
        budget = 0;
        while (done_count == start && budget < 2000) begin
            @(negedge aclk);
            #1;
            budget++;
        end
        checkOutput("done_seen", done_count - start, 1);
        checkOutput("cmd_ready_low_at_done", cmd_ready, 0);
    endtask

    task automatic checkBurst(input logic [7:0] base, input int len);
        int n;
        int data_errs;
        int last_errs;
        n = got_data.size();
        data_errs = 0;
        last_errs = 0;
        for (int i = 0; i < n; i++) begin
            if (got_data[i] !== beatData(base, i)) data_errs++;
            if (got_last[i] !== (i == len)) last_errs++;
        end
        checkOutput("beat_count", n, len + 1);
        checkOutput("beat_data_errs", data_errs, 0);
        checkOutput("beat_last_errs", last_errs, 0);
    endtask

    task automatic checkResetOutputs(input string phase);
        checkOutput({phase, "_arvalid"}, arvalid, 0);
        checkOutput({phase, "_rready"}, rready, 0);
        checkOutput({phase, "_out_valid"}, out_valid, 0);
        checkOutput({phase, "_out_last"}, out_last, 0);
        checkOutput({phase, "_done"}, done, 0);
        checkOutput({phase, "_err"}, err, 0);
        checkOutput({phase, "_araddr"}, araddr, 0);
        checkOutput({phase, "_arlen"}, arlen, 0);
        checkOutput({phase, "_out_data"}, out_data, 0);
        checkOutput({phase, "_cmd_ready"}, cmd_ready, 1);
    endtask

    initial begin
        int d0;
        int a0;
        areset    = 1'b1;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_valid = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        checkResetOutputs("reset");
        @(negedge aclk);
        areset = 1'b0;

        $display("[TB] single burst addr=7 len=5");
        d0 = done_count;
        a0 = ar_count;
        applyStimulus(8'd7, 8'd5);
        checkOutput("ar_valid", arvalid, 1);
        checkOutput("ar_addr", araddr, 7);
        checkOutput("ar_len", arlen, 5);
        checkOutput("ar_size", arsize, 2);
        checkOutput("ar_burst", arburst, 1);
        checkOutput("cmd_ready_busy", cmd_ready, 0);
        waitDone(d0);
        checkBurst(8'd7, 5);
        repeat (5) @(negedge aclk);
        #1;
        checkOutput("done_once", done_count - d0, 1);
        checkOutput("ar_once", ar_count - a0, 1);
        checkOutput("single_err", err, 0);
        checkOutput("cmd_ready_after", cmd_ready, 1);

        $display("[TB] backpressure len=3");
        bp_mode = 1'b1;
        d0 = done_count;
        applyStimulus(8'h20, 8'd3);
        waitDone(d0);
        checkBurst(8'h20, 3);
        bp_mode = 1'b0;

        $display("[TB] AR stall");
        ar_block = 1'b1;
        repeat (2) @(posedge aclk);
        d0 = done_count;
        applyStimulus(8'h33, 8'd2);
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            checkOutput("stall_arvalid", arvalid, 1);
            checkOutput("stall_araddr", araddr, 8'h33);
            checkOutput("stall_arlen", arlen, 2);
            checkOutput("stall_rready", rready, 0);
            checkOutput("stall_cmd_ready", cmd_ready, 0);
        end
        ar_block = 1'b0;
        waitDone(d0);
        checkBurst(8'h33, 2);

        $display("[TB] length edges len=0 then len=255");
        d0 = done_count;
        applyStimulus(8'h50, 8'd0);
        waitDone(d0);
        checkBurst(8'h50, 0);
        d0 = done_count;
        applyStimulus(8'h60, 8'd255);
        waitDone(d0);
        checkBurst(8'h60, 255);

        $display("[TB] protocol error len=4");
        rlast_bad = 1;
        rresp_bad = 0;
        d0 = done_count;
        applyStimulus(8'h70, 8'd4);
        waitDone(d0);
        checkBurst(8'h70, 4);
        @(negedge aclk);
        checkOutput("err_sticky", err, 1);
`ifdef AXI_RD_RESP_CHECK_EN
        checkOutput("err_resp", err_resp, 2'b10);
`endif
        rlast_bad = -1;
        rresp_bad = -1;

        $display("[TB] reset mid-burst");
        applyStimulus(8'h80, 8'd5);
        checkOutput("err_cleared_by_cmd", err, 0);
        begin
            int budget;
            budget = 0;
            while (got_data.size() < 3 && budget < 200) begin
                @(negedge aclk);
                #1;
                budget++;
            end
            checkOutput("mid_beats_reached", got_data.size(), 3);
        end
        areset = 1'b1;
        #1;
        checkResetOutputs("midreset");
        @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        d0 = done_count;
        applyStimulus(8'h90, 8'd2);
        waitDone(d0);
        checkBurst(8'h90, 2);
        @(negedge aclk);
        checkOutput("post_reset_err", err, 0);

        repeat (3) @(posedge aclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
